// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer.
// Borrows the external 32-bit ALU for every add/subtract. Multiply is
// shift-and-add, divide is restoring division, and each takes 32 steps.
// Carry and borrow are rebuilt from the operand and result MSBs, so the
// ALU overflow flag is not used.
// Optional build macro MULDIV_SIGNED_EN adds signed operation (op[1]).
// Signed operands are converted to their magnitudes at capture, and one
// FIX cycle then corrects the result signs.
//
// state       | meaning
// S_IDLE      | waiting for start; ALU driven with 0 + 0
// S_MUL_STEP  | one shift-and-add step per cycle, 32 steps
// S_DIV_CHECK | divisor routed through the ALU to test for zero
// S_DIV_STEP  | one restoring-division step per cycle, 32 steps
// S_FIX       | sign correction of a signed result (feature only)
// S_DONE      | one-cycle done pulse, then back to S_IDLE
module muldiv_seq #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] ADD_CODE = 3'b010,
  parameter logic [2:0] SUB_CODE = 3'b110
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ula_control,
  input  logic [WIDTH-1:0] ula_y,
  input  logic             ula_zero,
  input  logic             ula_overflow
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_STEP,
    S_DIV_CHECK,
    S_DIV_STEP,
`ifdef MULDIV_SIGNED_EN
    S_FIX,
`endif
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  state_t           after_steps;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [WIDTH-1:0] dbz_hi;
  logic             a_msb;
  logic             b_msb;
  logic             y_msb;
  logic             carry;
  logic             borrow;
  logic             take_sub;
  logic             unused_inputs;

`ifdef MULDIV_SIGNED_EN
  logic op_signed;
  logic op_div;
  logic sign_a;
  logic sign_b;
  logic req_signed;

  // Signed requests are converted to magnitudes by a local negator, so the
  // ALU is free for the iteration itself.
  assign req_signed    = op[1];
  assign cap_a         = (req_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign cap_b         = (req_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  // lo holds the dividend magnitude, so a zero divisor restores the original.
  assign dbz_hi        = sign_a ? -lo : lo;
  assign after_steps   = op_signed ? S_FIX : S_DONE;
  assign unused_inputs = ula_overflow;
`else
  assign cap_a         = src_a;
  assign cap_b         = src_b;
  assign dbz_hi        = lo;
  assign after_steps   = S_DONE;
  assign unused_inputs = ^{ula_overflow, op[1]};
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Unsigned carry-out and borrow rebuilt from the operand and result MSBs.
  assign a_msb    = ula_a[WIDTH-1];
  assign b_msb    = ula_b[WIDTH-1];
  assign y_msb    = ula_y[WIDTH-1];
  assign carry    = (a_msb & b_msb) | ((a_msb | b_msb) & ~y_msb);
  assign borrow   = (~a_msb & b_msb) | ((~a_msb | b_msb) & y_msb);
  // The shifted-out remainder bit means the partial remainder exceeds any divisor.
  assign take_sub = hi[WIDTH-1] | ~borrow;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and ALU operand/control selection.
  always_comb begin
    state_nx    = state;
    ula_a       = '0;
    ula_b       = '0;
    ula_control = ADD_CODE;
    case (state)
      S_IDLE: begin
        if (start) state_nx = op[0] ? S_DIV_CHECK : S_MUL_STEP;
      end
      S_MUL_STEP: begin
        ula_a = hi;
        ula_b = lo[0] ? mcand : '0;
        if (step == LAST_STEP) state_nx = after_steps;
      end
      S_DIV_CHECK: begin
        ula_a    = divisor;
        state_nx = ula_zero ? S_DONE : S_DIV_STEP;
      end
      S_DIV_STEP: begin
        ula_a       = {hi[WIDTH-2:0], lo[WIDTH-1]};
        ula_b       = divisor;
        ula_control = SUB_CODE;
        if (step == LAST_STEP) state_nx = after_steps;
      end
`ifdef MULDIV_SIGNED_EN
      S_FIX: state_nx = S_DONE;
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      divisor     <= '0;
      step        <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      op_signed   <= 1'b0;
      op_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            step        <= '0;
            hi          <= '0;
            if (op[0]) begin
              lo      <= cap_a;
              divisor <= cap_b;
            end else begin
              lo    <= cap_b;
              mcand <= cap_a;
            end
`ifdef MULDIV_SIGNED_EN
            op_signed <= req_signed;
            op_div    <= op[0];
            sign_a    <= req_signed & src_a[WIDTH-1];
            sign_b    <= req_signed & src_b[WIDTH-1];
`endif
          end
        end
        S_MUL_STEP: begin
          {hi, lo} <= {carry, ula_y, lo[WIDTH-1:1]};
          step     <= step + CW'(1);
        end
        S_DIV_CHECK: begin
          if (ula_zero) begin
            hi          <= dbz_hi;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end
        end
        S_DIV_STEP: begin
          if (take_sub) begin
            hi <= ula_y;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= ula_a;
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
          step <= step + CW'(1);
        end
`ifdef MULDIV_SIGNED_EN
        S_FIX: begin
          if (op_div) begin
            if (sign_a ^ sign_b) lo <= -lo;
            if (sign_a)          hi <= -hi;
          end else if (sign_a ^ sign_b) begin
            {hi, lo} <= -{hi, lo};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random and directed bench for muldiv_seq.
// The bench plays the part of the external ALU and checks results against
// plain 64-bit arithmetic, including the expected done latency.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo, ula_a, ula_b, ula_y;
  logic [2:0]   ula_control;
  logic         ula_zero, ula_overflow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic         pending = 1'b0;
  logic         after_done = 1'b0;
  logic [W-1:0] exp_hi, exp_lo, last_hi, last_lo;
  logic         exp_dbz, last_dbz;
  int           exp_lat, start_cyc, n_mon;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo),
    .ula_a(ula_a), .ula_b(ula_b), .ula_control(ula_control),
    .ula_y(ula_y), .ula_zero(ula_zero), .ula_overflow(ula_overflow)
  );

  // The ALU the sequencer borrows; unknown codes give a poison value.
  always_comb begin
    case (ula_control)
      3'b010:  ula_y = ula_a + ula_b;
      3'b110:  ula_y = ula_a - ula_b;
      default: ula_y = 32'hDEAD_BEEF;
    endcase
    ula_zero     = (ula_y == '0);
    ula_overflow = (ula_a[W-1] == ula_b[W-1]) && (ula_y[W-1] != ula_a[W-1]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results from plain arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el,
                       output logic ed, output int lat);
    logic [63:0] p;
    logic        sgn;
    longint      sa, sb;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    ed = 1'b0;
    if (!o[0]) begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      eh  = p[63:32];
      el  = p[31:0];
      lat = 33 + int'(sgn);
    end else if (b == '0) begin
      eh  = a;
      el  = '1;
      ed  = 1'b1;
      lat = 2;
    end else begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
        eh = 32'(sa % sb);
        el = 32'(sa / sb);
      end else begin
        eh = a % b;
        el = a / b;
      end
      lat = 34 + int'(sgn);
    end
  endtask

  // Single compare process: results and latency at done, busy while running,
  // held results and idle ALU drive otherwise.
  always @(negedge clk) begin
    if (reset) begin
      after_done = 1'b0;
    end else if (pending) begin
      n_mon = cyc - start_cyc;
      if (done) begin
        chk("latency", 64'(n_mon + 1), 64'(exp_lat));
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        chk("div_by_zero", div_by_zero, exp_dbz);
        chk("busy_at_done", busy, 1'b1);
        pending    = 1'b0;
        after_done = 1'b1;
        last_hi    = exp_hi;
        last_lo    = exp_lo;
        last_dbz   = exp_dbz;
      end else begin
        chk("busy_running", busy, 1'b1);
        if (n_mon >= exp_lat + 4) begin
          chk("done_timeout", 1'b0, 1'b1);
          pending = 1'b0;
        end
      end
    end else begin
      if (after_done) begin
        chk("done_one_cycle", done, 1'b0);
        after_done = 1'b0;
      end
      chk("idle_busy", busy, 1'b0);
      chk("hold_hi", hi, last_hi);
      chk("hold_lo", lo, last_lo);
      chk("hold_dbz", div_by_zero, last_dbz);
      chk("idle_ula_a", ula_a, '0);
      chk("idle_ula_b", ula_b, '0);
      chk("idle_ula_ctl", ula_control, 3'b010);
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    logic         ed;
    int           lat;
    model(o, a, b, eh, el, ed, lat);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    exp_hi = eh; exp_lo = el; exp_dbz = ed; exp_lat = lat;
    start_cyc = cyc;
    pending = 1'b1;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (pending && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (pending) begin
      chk("wait_done_timeout", 1'b0, 1'b1);
      pending = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(o, a, b);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]   o;
    logic [W-1:0] a, b;
    int           sel;

    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_ff_hi", hi, 32'hFFFF_FFFE);
    chk("multu_ff_lo", lo, 32'h0000_0001);

    run_op(2'b01, 32'd100, 32'd7);
    chk("divu_100_7_lo", lo, 32'd14);
    chk("divu_100_7_hi", hi, 32'd2);

    run_op(2'b01, 32'h8000_0000, 32'd1);
    chk("divu_top_lo", lo, 32'h8000_0000);
    chk("divu_top_hi", hi, 32'd0);

    run_op(2'b01, 32'h1234_5678, 32'd0);
    chk("dbz_flag", div_by_zero, 1'b1);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);
    chk("dbz_hi", hi, 32'h1234_5678);

    // 3*5 with ALU drive probes; this start also clears div_by_zero.
    start_op(2'b00, 32'd3, 32'd5);
    chk("dbz_cleared", div_by_zero, 1'b0);
    chk("step1_ctl", ula_control, 3'b010);
    chk("step1_a", ula_a, 32'd0);
    chk("step1_b", ula_b, 32'd3);
    @(posedge clk);
    #1;
    chk("step2_ctl", ula_control, 3'b010);
    chk("step2_b", ula_b, 32'd0);
    wait_done();
    chk("multu_3_5_lo", lo, 32'd15);
    chk("multu_3_5_hi", hi, 32'd0);

    run_op(2'b00, 32'd0, 32'hDEAD_BEEF);

    // A start pulse while busy must not disturb the running operation.
    start_op(2'b00, 32'h0001_2345, 32'h0006_789A);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'h5555_5555; src_b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset in the middle of a divide aborts it.
    start_op(2'b01, 32'hCAFE_F00D, 32'h0000_0123);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pending = 1'b0;
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    chk("abort_ctl", ula_control, 3'b010);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd1000, 32'd33);

`ifdef MULDIV_SIGNED_EN
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5);
    chk("mult_s_hi", hi, 32'hFFFF_FFFF);
    chk("mult_s_lo", lo, 32'hFFFF_FFF1);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    chk("div_s_lo", lo, 32'hFFFF_FFFD);
    chk("div_s_hi", hi, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: a = '0;
        3: a = 32'h8000_0000;
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(o, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that uses the 32-bit ALU as its only adder/subtractor.
- Acts as the initiator on the ALU operand/control interface: drives A, B and the control code, and consumes Y and zero.
- Sits beside the main datapath and serves MULT/DIV-class instructions through a start/busy/done handshake, producing HI/LO results.

Parameters:
- WIDTH, 32, operand/result word width; must equal the ALU width.
- ADD_CODE, 3'b010, ALU control code for add.
- SUB_CODE, 3'b110, ALU control code for subtract.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  op[0]: 0=multiply, 1=divide; op[1]: signed (used only with the feature).
- src_a  input  WIDTH  multiplicand / dividend.
- src_b  input  WIDTH  multiplier / divisor.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  set on a zero-divisor divide; held until next accepted start.
- hi  output  WIDTH  product high word / remainder.
- lo  output  WIDTH  product low word / quotient.
- ula_a  output  WIDTH  ALU operand A.
- ula_b  output  WIDTH  ALU operand B.
- ula_control  output  3  ALU control code.
- ula_y  input  WIDTH  ALU result.
- ula_zero  input  1  ALU zero flag.
- ula_overflow  input  1  ALU overflow flag; ignored, since unsigned carry/borrow are derived locally.

Behaviour:
- Reset (synchronous): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0.
- Reset asserted mid-operation aborts the operation and produces the same values on the next edge.
- ALU outputs in IDLE and DONE: ula_a=0, ula_b=0, ula_control=ADD_CODE.
- States: IDLE, MUL_STEP, DIV_CHECK, DIV_STEP, FIX (feature only), DONE.
- Step counter: 5 bits, counts 0..31; exit on the 32nd step.
- IDLE:
  - start=1 captures src_a/src_b and clears div_by_zero.
  - Multiply: hi=0, lo=src_b, mcand=src_a, go to MUL_STEP.
  - Divide: hi=0, lo=src_a, divisor=src_b, go to DIV_CHECK.
- start while busy is ignored, with no effect on the current operation.
- MUL_STEP:
  - Drive ula_a=hi, ula_b = lo[0] ? mcand : 0, ula_control=ADD_CODE.
  - Carry c = (a31&b31) | ((a31|b31)&~y31), computed from the driven operands and ula_y.
  - Update {hi,lo} <= {c, ula_y, lo[31:1]}.
  - After 32 steps go to DONE.
- DIV_CHECK:
  - Drive ula_a=divisor, ula_b=0, ADD_CODE.
  - If ula_zero=1: hi=dividend, lo=all-ones, div_by_zero=1, go to DONE.
  - Else go to DIV_STEP.
- DIV_STEP (restoring division):
  - Drive ula_a={hi[30:0], lo[31]}, ula_b=divisor, SUB_CODE.
  - Borrow bw = (~a31&b31) | ((~a31|b31)&y31).
  - If hi[31] | ~bw: hi<=ula_y, lo<={lo[30:0],1}.
  - Else: hi<=ula_a, lo<={lo[30:0],0}.
  - After 32 steps go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- hi/lo remain stable from DONE until the next accepted start.
- Latency, with start sampled at edge k: done high in cycle k+33 for multiply, k+34 for divide, k+2 for divide-by-zero.
- Boundary cases:
  - Operand 0 for multiply gives a 0 result in the full 32 steps; no early exit.
  - The 0x80000000 dividend top-bit case is handled by the hi[31] term.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op[1]=1 selects signed operation.
  - At capture, negative operands are replaced by their two's-complement magnitude using a local negator (not the ALU); operand signs are recorded.
  - Before DONE, one FIX cycle runs:
    - Multiply: negates the 64-bit {hi,lo} if the signs differ.
    - Divide: negates lo if the signs differ; hi takes the dividend's sign.
  - Signed latency is +1 cycle.
  - Signed divide-by-zero skips FIX and gives the same result as unsigned.
- Undefined: op[1] is ignored, all operations are unsigned, and the FIX state does not exist.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start, busy high throughout.
- DIVU 100/7 -> lo=14, hi=2, done at k+34; DIVU 0x80000000/1 -> lo=0x80000000, hi=0.
- DIVU 0x12345678/0 -> done at k+2, div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678; next accepted start clears div_by_zero.
- MULTU src_a=3, src_b=5, first MUL_STEP cycle -> ula_control=3'b010, ula_a=0, ula_b=3; second step -> ula_b=0; final lo=15, hi=0.
- start pulsed during step 10 is ignored; reset asserted at step 20 -> next cycle busy=0, done=0, hi=lo=0, state IDLE, ula_control=3'b010.
- With MULDIV_SIGNED_EN:
  - MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done at k+34.
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done at k+35.
